// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package inst_fetch_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;
    localparam int          DEF_Q_DEPTH  = 2;
    localparam int          IF_STATE_W   = 2;

    typedef enum logic [IF_STATE_W-1:0] {
        S_RST  = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if_fifo.sv
// Two-entry {pc, inst} queue between the fetch FSM and decode.
// Flush wins over push; push and pop together when full keeps the count.
module if_fifo
    import inst_fetch_pkg::*;
#(
    parameter int Q_DEPTH = DEF_Q_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  if_entry_t push_data,
    output if_entry_t head,
    output logic      full,
    output logic      empty
);

    if_entry_t  mem [Q_DEPTH];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // When full, the slot written by a simultaneous push is the one being popped.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == 2'(Q_DEPTH));
    assign empty = (count == 2'd0);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: owns the PC, issues imem word requests and
// feeds decode from a two-entry queue, handling redirects and wrong-path drops.
//
// state  | meaning
// S_RST  | one-cycle settle after reset
// S_REQ  | request at fetch_pc held until granted
// S_WAIT | one request outstanding, waiting for rvalid
// S_HOLD | queue full, waiting for decode to pop
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST,
    parameter int          Q_DEPTH  = DEF_Q_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_vld,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        id_stall,
    input  logic        id_jmp_vld,
    input  logic [31:0] id_jmp_addr,
    input  logic        ex_jmp_vld,
    input  logic [31:0] ex_jmp_addr
);

    if_state_e   state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] issued_pc_q, issued_pc_d;
    logic [31:0] last_pc_q;
    logic        discard_q, discard_d;

    logic        redir_ex, redir_id, redir;
    logic [31:0] redir_pc;
    logic        fifo_push, fifo_pop, fifo_flush;
    logic        fifo_full, fifo_empty, next_full;
    if_entry_t   fifo_head, push_entry;

    assign redir_ex = ex_jmp_vld;
    assign redir_id = id_jmp_vld && if_vld && !id_stall;
    assign redir    = redir_ex || redir_id;
    assign redir_pc = word_align(redir_ex ? ex_jmp_addr : id_jmp_addr);

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = fetch_pc_q;

    // A response coinciding with a redirect is wrong-path and is dropped.
    assign fifo_push  = (state_q == S_WAIT) && imem_rvalid && !discard_q && !redir;
    assign fifo_pop   = if_vld && !id_stall;
    assign fifo_flush = redir;
    assign push_entry = '{pc: issued_pc_q, inst: imem_rdata};

    assign next_full = fifo_full ? (!fifo_pop || fifo_push)
                                 : (!fifo_empty && fifo_push && !fifo_pop);

    if_fifo #(
        .Q_DEPTH (Q_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .push_data (push_entry),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign if_vld  = !fifo_empty;
    assign if_inst = fifo_empty ? NOP_INST : fifo_head.inst;
    assign if_pc   = fifo_empty ? last_pc_q : fifo_head.pc;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        discard_d   = discard_q;

        if (imem_rvalid && discard_q) begin
            discard_d = 1'b0;
        end

        case (state_q)
            S_RST: state_d = S_REQ;
            S_REQ: begin
                if (imem_gnt) begin
                    fetch_pc_d  = fetch_pc_q + 32'd4;
                    issued_pc_d = fetch_pc_q;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = next_full ? S_HOLD : S_REQ;
                end
            end
            S_HOLD: begin
                if (fifo_pop) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_RST;
        endcase

        // A request still in flight (or granted right now) must be thrown away.
        if (redir) begin
            fetch_pc_d = redir_pc;
            if ((state_q == S_WAIT && !imem_rvalid) || (state_q == S_REQ && imem_gnt)) begin
                state_d   = S_WAIT;
                discard_d = 1'b1;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RST;
            fetch_pc_q  <= RESET_PC;
            issued_pc_q <= RESET_PC;
            last_pc_q   <= RESET_PC;
            // Pre-reset response still owed by memory must not reach the queue.
            discard_q   <= (state_q == S_WAIT && !imem_rvalid)
                        || (state_q == S_REQ && imem_gnt)
                        || (discard_q && !imem_rvalid);
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
            discard_q   <= discard_d;
            if (!fifo_empty) begin
                last_pc_q <= fifo_head.pc;
            end
        end
    end

endmodule
